div_sched_ctrl: RTL and testbench

- Run-time controller for a programmable integer clock-enable divider.
- Sequences start/stop of the divider period counter. Accepts new divide ratios over a valid/ready handshake and applies them only at period boundaries, so no runt periods occur.
- Outputs are a one-cycle tick enable per period and a near-50% phase signal, for downstream logic clocked on sys_clk.

---
 rtl/div_sched_pkg.sv | 12 +
 rtl/div_period_cnt.sv | 27 ++
 rtl/div_sched_ctrl.sv | 107 ++++++++++
 tb/tb_div_sched_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_sched_pkg.sv
// Shared types and constants for the clock-enable divider scheduler.
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/div_period_cnt.sv
// Period counter: counts 0..div-1 while running and wraps, held at zero when cleared.
module div_period_cnt
    import div_sched_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             run,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    // div is always >= DIV_MIN, so div-1 cannot underflow
    assign last = (cnt == (div - CNT_W'(1)));

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= last ? '0 : (cnt + CNT_W'(1));
        end
    end

endmodule

// File: rtl/div_sched_ctrl.sv
// Run-time controller for a programmable clock-enable divider; new ratios take
// effect only at period boundaries so no runt periods are produced.
module div_sched_ctrl
    import div_sched_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_DIV = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             phase_hi,
    output logic [CNT_W-1:0] cur_div,
    output logic             running
);

    localparam int unsigned HW = CNT_W + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             cfg_err_q, cfg_err_d;

    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             hs;
    logic             cfg_bad;
    logic             cfg_good;
    logic [HW-1:0]    half_len;

    div_period_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .run     (running),
        .clr     (state_q == IDLE),
        .div     (cur_div_q),
        .cnt     (cnt),
        .last    (last)
    );

    assign running   = (state_q != IDLE);
    assign cfg_ready = (state_q != PEND);
    assign hs        = cfg_valid & cfg_ready;
    assign cfg_bad   = (cfg_div < CNT_W'(DIV_MIN));
    assign cfg_good  = hs & ~cfg_bad;

    // ceil(N/2) computed one bit wider so N = 2^CNT_W-1 does not overflow
    assign half_len  = (HW'(cur_div_q) + HW'(1)) >> 1;

    assign tick      = running & last;
    assign phase_hi  = running & (HW'(cnt) < half_len);
    assign cur_div   = cur_div_q;
    assign cfg_err   = cfg_err_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            cur_div_q  <= CNT_W'(DEF_DIV);
            pend_div_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        cfg_err_d  = hs & cfg_bad;

        unique case (state_q)
            IDLE: begin
                if (cfg_good) cur_div_d = cfg_div;
                if (en)       state_d   = RUN;
            end
            RUN: begin
                if (last) begin
                    // a ratio arriving on the boundary applies to the very next period
                    if (cfg_good) cur_div_d = cfg_div;
                    state_d = en ? RUN : IDLE;
                end else if (cfg_good) begin
                    pend_div_d = cfg_div;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (last) begin
                    cur_div_d = pend_div_q;
                    state_d   = en ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_div_sched_ctrl.sv
// Scoreboard bench for div_sched_ctrl: directed scenarios followed by random traffic.
module tb_div_sched_ctrl;

    localparam int unsigned CNT_W   = 8;
    localparam int          DEF_DIV = 5;

    logic             sys_clk;
    logic             sys_rst;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             tick;
    logic             phase_hi;
    logic [CNT_W-1:0] cur_div;
    logic             running;

    div_sched_ctrl #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .phase_hi  (phase_hi),
        .cur_div   (cur_div),
        .running   (running)
    );

    typedef struct {
        int cyc;
        bit tick;
        bit phase;
        bit ready;
        bit err;
        bit run;
        int cur;
    } exp_t;

    exp_t exp_q[$];

    int  n_cmp  = 0;
    int  n_bad  = 0;
    int  cyc    = 0;
    bit  done   = 0;

    // Reference model: period position, ratio in force, optional waiting ratio
    bit  m_run;
    int  m_pos;
    int  m_cur;
    int  m_pend;
    bit  m_err;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic model_reset();
        m_run  = 1'b0;
        m_pos  = 0;
        m_cur  = DEF_DIV;
        m_pend = -1;
        m_err  = 1'b0;
    endtask

    task automatic model_next(input bit r, input bit e, input bit v, input int d);
        bit hs;
        bit good;
        if (r) begin
            model_reset();
            return;
        end
        hs    = v && (m_pend < 0);
        m_err = hs && (d < 2);
        good  = hs && (d >= 2);
        if (!m_run) begin
            if (good) m_cur = d;
            m_pos = 0;
            m_run = e;
        end else if (m_pos == m_cur - 1) begin
            if (m_pend >= 0)  m_cur = m_pend;
            else if (good)    m_cur = d;
            m_pend = -1;
            m_pos  = 0;
            m_run  = e;
        end else begin
            m_pos = m_pos + 1;
            if (good) m_pend = d;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit v, input int d);
        exp_t x;
        @(posedge sys_clk);
        #1;
        cyc       = cyc + 1;
        sys_rst   = r;
        en        = e;
        cfg_valid = v;
        cfg_div   = CNT_W'(d);
        x.cyc   = cyc;
        x.tick  = m_run && (m_pos == m_cur - 1);
        x.phase = m_run && (m_pos < (m_cur + 1) / 2);
        x.ready = (m_pend < 0);
        x.err   = m_err;
        x.run   = m_run;
        x.cur   = m_cur;
        exp_q.push_back(x);
        model_next(r, e, v, d);
    endtask

    task automatic idle_steps(input int n, input bit e);
        for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 0);
    endtask

    // Advance with en=1 until the next driven cycle sits at period position p
    task automatic run_until(input int p);
        for (int i = 0; i < 600 && !(m_run && m_pos == p); i++) step(1'b0, 1'b1, 1'b0, 0);
    endtask

    // Monitor: compare every presented cycle against the scoreboard
    initial begin : monitor
        exp_t e;
        bit   bad;
        forever begin
            @(negedge sys_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp = n_cmp + 1;
                bad = 1'b0;
                if (tick !== e.tick) begin
                    bad = 1'b1;
                    $display("FAIL tick cyc %0d: got %0b, want %0b", e.cyc, tick, e.tick);
                end
                if (phase_hi !== e.phase) begin
                    bad = 1'b1;
                    $display("FAIL phase_hi cyc %0d: got %0b, want %0b", e.cyc, phase_hi, e.phase);
                end
                if (cfg_ready !== e.ready) begin
                    bad = 1'b1;
                    $display("FAIL cfg_ready cyc %0d: got %0b, want %0b", e.cyc, cfg_ready, e.ready);
                end
                if (cfg_err !== e.err) begin
                    bad = 1'b1;
                    $display("FAIL cfg_err cyc %0d: got %0b, want %0b", e.cyc, cfg_err, e.err);
                end
                if (running !== e.run) begin
                    bad = 1'b1;
                    $display("FAIL running cyc %0d: got %0b, want %0b", e.cyc, running, e.run);
                end
                if (int'(cur_div) != e.cur) begin
                    bad = 1'b1;
                    $display("FAIL cur_div cyc %0d: got %0d, want %0d", e.cyc, cur_div, e.cur);
                end
                if (bad) n_bad = n_bad + 1;
            end else if (done) begin
                break;
            end
        end
        if (n_cmp < 100) begin
            n_bad = n_bad + 1;
            $display("FAIL coverage: got %0d compared cycles, want at least 100", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time, got timeout, want completion");
        $fatal(1);
    end

    initial begin : driver
        int r;
        int d;
        sys_rst   = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        repeat (2) @(posedge sys_clk);
        model_reset();

        // reset state, then free-run at the default ratio
        step(1'b1, 1'b0, 1'b0, 0);
        idle_steps(16, 1'b1);

        // ratio 3 accepted mid-period waits for the boundary
        run_until(1);
        step(1'b0, 1'b1, 1'b1, 3);
        idle_steps(15, 1'b1);

        // ratio 8 offered on the tick cycle applies immediately
        run_until(2);
        step(1'b0, 1'b1, 1'b1, 8);
        idle_steps(20, 1'b1);

        // invalid ratios pulse cfg_err and change nothing
        step(1'b0, 1'b1, 1'b1, 1);
        idle_steps(3, 1'b1);
        step(1'b0, 1'b1, 1'b1, 0);
        idle_steps(12, 1'b1);

        // back to ratio 5, drop en mid-period, then re-raise
        run_until(7);
        step(1'b0, 1'b1, 1'b1, 5);
        run_until(1);
        idle_steps(12, 1'b0);
        idle_steps(14, 1'b1);

        // reset while a ratio of 7 is pending discards it
        run_until(1);
        step(1'b0, 1'b1, 1'b1, 7);
        step(1'b1, 1'b1, 1'b0, 0);
        idle_steps(14, 1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10)      d = int'($urandom_range(0, 1));
            else if (r < 92) d = int'($urandom_range(2, 12));
            else             d = int'($urandom_range(13, 255));
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 4) == 0), d);
        end

        idle_steps(2, 1'b0);
        done = 1'b1;
    end

endmodule
